// File: rtl/round_key_store.sv
// round_key_store
//   Holds one complete AES round-key schedule (NUM_KEYS keys of KEY_W bits)
//   written by the key-expansion engine. The cipher can then sweep it any
//   number of times, either forward (encrypt order) or reverse (decrypt
//   order), at one key per cycle.
//
// Ports
//   clk          single clock, all state on the rising edge
//   rst          asynchronous, active-high reset
//   load_start   pulse: discard whatever is going on and capture a new schedule
//   rk_valid     producer presents a round key on rk_in
//   rk_in        round key, round 0 delivered first
//   rk_ready     store accepts rk_in this cycle (LOAD state)
//   loaded       a complete schedule is held
//   rd_req       pulse: start a read sweep (honoured only when loaded and idle)
//   rd_dir       sampled with rd_req: 0 = rounds 0..N-1, 1 = rounds N-1..0
//   rk_out       registered round key to the cipher (holds when not valid)
//   rk_out_valid rk_out carries a key this cycle
//   rk_round     round index of rk_out (holds when not valid)
//   rd_done      pulse coincident with the last key of a sweep
module round_key_store #(
    parameter int NUM_KEYS = 15,
    parameter int KEY_W    = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             rk_valid,
    input  logic [KEY_W-1:0] rk_in,
    output logic             rk_ready,
    output logic             loaded,
    input  logic             rd_req,
    input  logic             rd_dir,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_out_valid,
    output logic [3:0]       rk_round,
    output logic             rd_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] READY = 2'd2;
    localparam logic [1:0] READ  = 2'd3;

    localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);

    logic [1:0]       state;
    logic [3:0]       wr_ptr;
    logic [3:0]       rd_ptr;
    logic             dir_p0;
    logic [KEY_W-1:0] mem [NUM_KEYS];

    logic             wr_en;
    logic             start_read;
    logic [3:0]       rd_idx;
    logic             serve_dir;
    logic             serve_last;
    logic [3:0]       serve_next;

    assign rk_ready = (state == LOAD);
    assign loaded   = (state == READY) || (state == READ);

    // load_start has priority over everything, so it also vetoes a
    // coincident write or sweep start.
    assign wr_en      = (state == LOAD) && rk_valid && !load_start;
    assign start_read = (state == READY) && rd_req && !load_start;

    // The first key of a sweep is served straight from the start index so
    // that it appears the cycle after rd_req; later keys come from rd_ptr.
    assign rd_idx     = start_read ? (rd_dir ? LAST_IDX : 4'd0) : rd_ptr;
    assign serve_dir  = start_read ? rd_dir : dir_p0;
    assign serve_last = serve_dir ? (rd_idx == 4'd0) : (rd_idx == LAST_IDX);
    // The pointer parks on the final index instead of stepping past it.
    assign serve_next = serve_last ? rd_idx
                      : (serve_dir ? rd_idx - 4'd1 : rd_idx + 4'd1);

    // Key storage is deliberately not reset; loaded=0 marks it stale.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= rk_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= 4'd0;
            rd_ptr       <= 4'd0;
            dir_p0       <= 1'b0;
            rk_out       <= '0;
            rk_out_valid <= 1'b0;
            rk_round     <= 4'd0;
            rd_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state  <= LOAD;
                        wr_ptr <= 4'd0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wr_ptr <= 4'd0;
                    end else if (rk_valid) begin
                        if (wr_ptr == LAST_IDX) begin
                            state  <= READY;
                            wr_ptr <= 4'd0;
                        end else begin
                            wr_ptr <= wr_ptr + 4'd1;
                        end
                    end
                end
                READY: begin
                    if (load_start) begin
                        state  <= LOAD;
                        wr_ptr <= 4'd0;
                    end else if (rd_req) begin
                        state        <= READ;
                        dir_p0       <= rd_dir;
                        rk_out       <= mem[rd_idx];
                        rk_round     <= rd_idx;
                        rk_out_valid <= 1'b1;
                        rd_done      <= serve_last;
                        rd_ptr       <= serve_next;
                    end
                end
                READ: begin
                    if (load_start) begin
                        state        <= LOAD;
                        wr_ptr       <= 4'd0;
                        rk_out_valid <= 1'b0;
                        rd_done      <= 1'b0;
                    end else if (rd_done) begin
                        state        <= READY;
                        rk_out_valid <= 1'b0;
                        rd_done      <= 1'b0;
                    end else begin
                        rk_out   <= mem[rd_idx];
                        rk_round <= rd_idx;
                        rd_done  <= serve_last;
                        rd_ptr   <= serve_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store
//   Directed bench for round_key_store: a cycle table covering load, forward
//   and reverse sweeps, followed by hand-written sequences for gapped loads,
//   aborts, priority collisions and reset in the middle of a load.
module tb_round_key_store;

    localparam int NK = 15;
    localparam int KW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          rk_valid;
    logic [KW-1:0] rk_in;
    logic          rk_ready;
    logic          loaded;
    logic          rd_req;
    logic          rd_dir;
    logic [KW-1:0] rk_out;
    logic          rk_out_valid;
    logic [3:0]    rk_round;
    logic          rd_done;

    int errors = 0;
    int checks = 0;

    logic [KW-1:0] key [NK];

    typedef struct {
        logic          ls;
        logic          vl;
        logic [KW-1:0] din;
        logic          rq;
        logic          dr;
        logic          e_rdy;
        logic          e_ld;
        logic          e_vld;
        logic          e_done;
        logic [KW-1:0] e_out;
        logic [3:0]    e_rnd;
    } vec_t;

    vec_t tbl[$];

    round_key_store #(.NUM_KEYS(NK), .KEY_W(KW)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .rk_valid     (rk_valid),
        .rk_in        (rk_in),
        .rk_ready     (rk_ready),
        .loaded       (loaded),
        .rd_req       (rd_req),
        .rd_dir       (rd_dir),
        .rk_out       (rk_out),
        .rk_out_valid (rk_out_valid),
        .rk_round     (rk_round),
        .rd_done      (rd_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int ls, input int vl, input logic [KW-1:0] din,
                                input int rq, input int dr, input int e_rdy, input int e_ld,
                                input int e_vld, input int e_done, input logic [KW-1:0] e_out,
                                input int e_rnd);
        vec_t v;
        v.ls = 1'(ls);     v.vl = 1'(vl);     v.din = din;
        v.rq = 1'(rq);     v.dr = 1'(dr);
        v.e_rdy = 1'(e_rdy); v.e_ld = 1'(e_ld);
        v.e_vld = 1'(e_vld); v.e_done = 1'(e_done);
        v.e_out = e_out;   v.e_rnd = 4'(e_rnd);
        return v;
    endfunction

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic chk_key(input string name, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_rnd(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; return just after the
    // following rising edge so the registered outputs can be sampled.
    task automatic cyc(input int ls, input int vl, input logic [KW-1:0] din,
                       input int rq, input int dr);
        @(negedge clk);
        load_start = 1'(ls);
        rk_valid   = 1'(vl);
        rk_in      = din;
        rd_req     = 1'(rq);
        rd_dir     = 1'(dr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input int e_rdy, input int e_ld,
                           input int e_vld, input int e_done);
        chk_bit({tag, " rk_ready"},     rk_ready,     1'(e_rdy));
        chk_bit({tag, " loaded"},       loaded,       1'(e_ld));
        chk_bit({tag, " rk_out_valid"}, rk_out_valid, 1'(e_vld));
        chk_bit({tag, " rd_done"},      rd_done,      1'(e_done));
    endtask

    task automatic chk_reset_state(input string tag);
        chk_ctl(tag, 0, 0, 0, 0);
        chk_key({tag, " rk_out"},   rk_out,   '0);
        chk_rnd({tag, " rk_round"}, rk_round, 4'd0);
    endtask

    // Load all NK keys (each XORed with msk), inserting gap idle cycles
    // before every key; optionally start with a load_start pulse.
    task automatic load_keys(input logic [KW-1:0] msk, input int gap, input int do_start);
        if (do_start != 0) begin
            cyc(1, 0, '0, 0, 0);
            chk_ctl("load start", 1, 0, 0, 0);
        end
        for (int i = 0; i < NK; i++) begin
            for (int g = 0; g < gap; g++) begin
                cyc(0, 0, '0, 0, 0);
                chk_bit($sformatf("gap k%0d rk_ready", i), rk_ready, 1'b1);
                chk_bit($sformatf("gap k%0d loaded", i),   loaded,   1'b0);
            end
            cyc(0, 1, key[i] ^ msk, 0, 0);
            chk_bit($sformatf("load k%0d loaded", i),   loaded,   (i == NK - 1));
            chk_bit($sformatf("load k%0d rk_ready", i), rk_ready, (i != NK - 1));
        end
    endtask

    task automatic read_fwd(input logic [KW-1:0] msk, input string tag);
        cyc(0, 0, '0, 1, 0);
        for (int j = 0; j < NK; j++) begin
            if (j > 0) cyc(0, 0, '0, 0, 0);
            chk_bit($sformatf("%s r%0d valid", tag, j), rk_out_valid, 1'b1);
            chk_key($sformatf("%s r%0d rk_out", tag, j), rk_out, key[j] ^ msk);
            chk_rnd($sformatf("%s r%0d rk_round", tag, j), rk_round, 4'(j));
            chk_bit($sformatf("%s r%0d rd_done", tag, j), rd_done, (j == NK - 1));
        end
        cyc(0, 0, '0, 0, 0);
        chk_bit({tag, " after sweep valid"}, rk_out_valid, 1'b0);
        chk_bit({tag, " after sweep loaded"}, loaded, 1'b1);
    endtask

    initial begin
        key[0] = 128'h642423baa95efb4362d3f2ce993c0904;
        key[1] = 128'h150f258aa1fe796841d7b4429c9b5a30;
        for (int i = 2; i < NK; i++) begin
            key[i] = {4{8'hA5, 8'(i), 8'h5A, 8'(i)}};
        end

        // Cycle table: load, forward sweep (with ignored rd_req), reverse sweep.
        tbl.push_back(mk(1, 0, '0, 0, 0, 1, 0, 0, 0, '0, 0));
        for (int i = 0; i < NK; i++) begin
            tbl.push_back(mk(0, 1, key[i], 0, 0, (i == NK - 1) ? 0 : 1,
                             (i == NK - 1) ? 1 : 0, 0, 0, '0, 0));
        end
        tbl.push_back(mk(0, 0, '0, 0, 0, 0, 1, 0, 0, '0, 0));
        tbl.push_back(mk(0, 0, '0, 1, 0, 0, 1, 1, 0, key[0], 0));
        for (int j = 1; j < NK; j++) begin
            tbl.push_back(mk(0, 0, '0, (j == 4) ? 1 : 0, (j == 4) ? 1 : 0, 0, 1, 1,
                             (j == NK - 1) ? 1 : 0, key[j], j));
        end
        // rd_req while the last key is on the bus must not restart the sweep.
        tbl.push_back(mk(0, 0, '0, 1, 0, 0, 1, 0, 0, key[NK-1], NK - 1));
        tbl.push_back(mk(0, 0, '0, 1, 1, 0, 1, 1, 0, key[NK-1], NK - 1));
        for (int j = NK - 2; j >= 0; j--) begin
            tbl.push_back(mk(0, 0, '0, 0, 0, 0, 1, 1, (j == 0) ? 1 : 0, key[j], j));
        end
        tbl.push_back(mk(0, 0, '0, 0, 0, 0, 1, 0, 0, key[0], 0));

        // Reset: outputs forced low while rst is high, then rd_req ignored.
        rst = 1'b1; load_start = 1'b0; rk_valid = 1'b0; rk_in = '0;
        rd_req = 1'b0; rd_dir = 1'b0;
        #3;
        chk_reset_state("reset");
        #7;
        rst = 1'b0;
        cyc(0, 0, '0, 1, 0);
        chk_reset_state("rd_req after reset");
        cyc(0, 0, '0, 1, 1);
        chk_bit("rd_req dir1 after reset valid", rk_out_valid, 1'b0);

        foreach (tbl[i]) begin
            cyc(tbl[i].ls, tbl[i].vl, tbl[i].din, tbl[i].rq, tbl[i].dr);
            chk_ctl($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_ld,
                    tbl[i].e_vld, tbl[i].e_done);
            chk_key($sformatf("vec%0d rk_out", i),   rk_out,   tbl[i].e_out);
            chk_rnd($sformatf("vec%0d rk_round", i), rk_round, tbl[i].e_rnd);
        end

        // Gapped load with new data, then forward sweep of the new data.
        load_keys('1, 3, 1);
        read_fwd('1, "gapped");

        // load_start coincident with rk_valid: the key is dropped, restart at 0.
        cyc(1, 0, '0, 0, 0);
        cyc(0, 1, {4{32'hDEADBEEF}}, 0, 0);
        cyc(0, 1, {4{32'hFEEDFACE}}, 0, 0);
        cyc(1, 1, {4{32'hBADC0FFE}}, 0, 0);
        chk_ctl("restart in load", 1, 0, 0, 0);
        load_keys('0, 0, 0);
        read_fwd('0, "restart");

        // load_start and rd_req together in READY: load wins.
        cyc(1, 0, '0, 1, 0);
        chk_ctl("ls+rd_req", 1, 0, 0, 0);
        cyc(0, 0, '0, 0, 0);
        chk_bit("ls+rd_req next valid", rk_out_valid, 1'b0);
        load_keys('0, 0, 0);

        // Abort in the middle of a sweep while round 5 is on the bus.
        cyc(0, 0, '0, 1, 0);
        for (int j = 1; j <= 5; j++) cyc(0, 0, '0, 0, 0);
        chk_rnd("abort pre rk_round", rk_round, 4'd5);
        cyc(1, 0, '0, 0, 0);
        chk_ctl("abort", 1, 0, 0, 0);
        chk_key("abort rk_out hold", rk_out, key[5]);
        chk_rnd("abort rk_round hold", rk_round, 4'd5);
        cyc(0, 0, '0, 1, 0);
        chk_ctl("rd_req in load", 1, 0, 0, 0);
        cyc(0, 0, '0, 0, 0);
        chk_bit("rd_req in load later valid", rk_out_valid, 1'b0);

        // Reset after 7 accepted keys.
        for (int i = 0; i < 7; i++) cyc(0, 1, key[i], 0, 0);
        chk_ctl("mid-load", 1, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("reset mid-load");
        #9;
        rst = 1'b0;
        cyc(0, 0, '0, 1, 0);
        chk_reset_state("rd_req after mid-load reset");
        cyc(0, 1, key[7], 0, 0);
        chk_ctl("rk_valid in idle", 0, 0, 0, 0);
        load_keys('0, 0, 1);
        read_fwd('0, "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
